ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have EX-side inputs: aluResult 16, writeData 16 (store data), storeSrcReg 3, MemWrite 1, MemRead 1, RegWrite 1, MemToReg 1, writeReg 3, halt 1, valid 1.
REQ-004 SHALL have control inputs:
- stall 1: hold contents.
- flush 1: insert bubble.
REQ-005 SHALL have MEM/WB-side input memDataMemWb 16, the load data currently in MEM/WB.
REQ-006 SHALL have outputs, all registered: memAddr 16, writeDataOut 16, MemWriteOut 1, MemReadOut 1, RegWriteOut 1, MemToRegOut 1, writeRegOut 3, haltOut 1, validOut 1, forwardC 1, halted 1.

Function
REQ-007 SHALL implement states RUN, HALT_SEEN and DONE.
REQ-008 SHALL apply update priority per edge, highest first: reset, DONE, flush, stall, load.
REQ-009 Load (RUN, no flush, no stall) SHALL capture all EX inputs into the matching outputs, with memAddr=aluResult, writeDataOut=writeData and validOut=valid.
REQ-010 On load, each control output SHALL be its input ANDed with valid, so an invalid slot never drives MemWrite, MemRead, RegWrite or halt.
REQ-011 Latency SHALL be exactly one cycle from input to output.
REQ-012 On load, forwardC SHALL become 1 iff all of:
- MemWrite & valid;
- RegWriteOut & MemToRegOut & validOut (pre-edge values);
- storeSrcReg == writeRegOut (pre-edge).
REQ-013 On load, forwardC SHALL otherwise become 0.
REQ-014 Flush SHALL clear validOut, MemWriteOut, MemReadOut, RegWriteOut, MemToRegOut, haltOut and forwardC to 0, and SHALL leave the data fields unchanged.
REQ-015 Flush SHALL win over simultaneous stall.
REQ-016 A halt arriving together with flush SHALL be discarded.
REQ-017 Stall SHALL hold all outputs, with one exception.
REQ-018 The stall exception: if forwardC=1 at the edge, writeDataOut SHALL take memDataMemWb and forwardC SHALL clear to 0, capturing the forwarded value before MEM/WB advances.
REQ-019 RUN SHALL go to HALT_SEEN when a load captures halt&valid=1.
REQ-020 haltOut SHALL be 1 only while in HALT_SEEN.
REQ-021 HALT_SEEN SHALL go to DONE on the next edge regardless of stall or flush, so haltOut is exactly one cycle wide.
REQ-022 On entering DONE, all control outputs, validOut and forwardC SHALL be 0.
REQ-023 In DONE, halted SHALL be 1 and all inputs SHALL be ignored until reset.
REQ-024 halted SHALL be 0 in RUN and HALT_SEEN.
REQ-025 writeReg and storeSrcReg SHALL be compared as full 3-bit values, with no wrap or extension.
REQ-026 No arithmetic SHALL be performed on data fields.

Reset
REQ-027 While rst=0, the block SHALL immediately (asynchronously) drive state=RUN and every output to 0, including memAddr, writeDataOut, writeRegOut, forwardC and halted.
REQ-028 Reset asserted mid-HALT_SEEN or in DONE SHALL return the block to RUN with haltOut=0, and no dump pulse SHALL be generated.
REQ-029 The first edge after rst rises SHALL perform a normal load.

Verification
REQ-030 Load then store: load writeReg=3, MemToReg=1, RegWrite=1, valid=1, followed next cycle by a store with storeSrcReg=3 -> forwardC=1 in the store's MEM cycle; with storeSrcReg=4 instead -> forwardC=0.
REQ-031 Stall with forward pending: forwardC=1, memDataMemWb=16'hBEEF, stall=1 for 2 cycles -> after the first edge writeDataOut=16'hBEEF and forwardC=0; the second stall edge leaves both unchanged.
REQ-032 Flush plus stall: flush=1 and stall=1 together -> validOut=0, MemWriteOut=0, RegWriteOut=0, data fields unchanged.
REQ-033 Halt, then garbage: halt=1, valid=1, followed by further stores -> haltOut high exactly 1 cycle, then halted=1 and MemWriteOut=0 permanently.
REQ-034 Invalid slot: valid=0 with MemWrite=1 and halt=1 -> MemWriteOut=0, haltOut=0, state stays RUN.
REQ-035 Asynchronous reset: rst driven low between clock edges while in HALT_SEEN -> all outputs 0 without waiting for an edge; the next valid load after release propagates normally.

Source files
------------

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with store-data forwarding and halt sequencing
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResult,
  input  logic [15:0] writeData,
  input  logic [2:0]  storeSrcReg,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic [2:0]  writeReg,
  input  logic        halt,
  input  logic        valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] memDataMemWb,
  output logic [15:0] memAddr,
  output logic [15:0] writeDataOut,
  output logic        MemWriteOut,
  output logic        MemReadOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [2:0]  writeRegOut,
  output logic        haltOut,
  output logic        validOut,
  output logic        forwardC,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, HALT_SEEN, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        mw_q, mw_d, mr_q, mr_d, rw_q, rw_d, m2r_q, m2r_d;
  logic [2:0]  wreg_q, wreg_d;
  logic        halt_q, halt_d, valid_q, valid_d, fwd_q, fwd_d, halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mw_d     = mw_q;
    mr_d     = mr_q;
    rw_d     = rw_q;
    m2r_d    = m2r_q;
    wreg_d   = wreg_q;
    halt_d   = halt_q;
    valid_d  = valid_q;
    fwd_d    = fwd_q;
    halted_d = halted_q;
    case (state_q)
      HALT_SEEN: begin
        state_d  = DONE;
        mw_d     = 1'b0;
        mr_d     = 1'b0;
        rw_d     = 1'b0;
        m2r_d    = 1'b0;
        halt_d   = 1'b0;
        valid_d  = 1'b0;
        fwd_d    = 1'b0;
        halted_d = 1'b1;
      end
      RUN: begin
        if (flush) begin
          mw_d    = 1'b0;
          mr_d    = 1'b0;
          rw_d    = 1'b0;
          m2r_d   = 1'b0;
          halt_d  = 1'b0;
          valid_d = 1'b0;
          fwd_d   = 1'b0;
        end else if (stall) begin
          // Grab the load result now; MEM/WB will have moved on when the stall lifts.
          if (fwd_q) begin
            wdata_d = memDataMemWb;
            fwd_d   = 1'b0;
          end
        end else begin
          addr_d  = aluResult;
          wdata_d = writeData;
          mw_d    = MemWrite & valid;
          mr_d    = MemRead & valid;
          rw_d    = RegWrite & valid;
          m2r_d   = MemToReg & valid;
          wreg_d  = writeReg;
          halt_d  = halt & valid;
          valid_d = valid;
          fwd_d   = MemWrite & valid & rw_q & m2r_q & valid_q & (storeSrcReg == wreg_q);
          if (halt & valid) state_d = HALT_SEEN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      addr_q   <= '0;
      wdata_q  <= '0;
      mw_q     <= 1'b0;
      mr_q     <= 1'b0;
      rw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      wreg_q   <= '0;
      halt_q   <= 1'b0;
      valid_q  <= 1'b0;
      fwd_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mw_q     <= mw_d;
      mr_q     <= mr_d;
      rw_q     <= rw_d;
      m2r_q    <= m2r_d;
      wreg_q   <= wreg_d;
      halt_q   <= halt_d;
      valid_q  <= valid_d;
      fwd_q    <= fwd_d;
      halted_q <= halted_d;
    end
  end

  assign memAddr      = addr_q;
  assign writeDataOut = wdata_q;
  assign MemWriteOut  = mw_q;
  assign MemReadOut   = mr_q;
  assign RegWriteOut  = rw_q;
  assign MemToRegOut  = m2r_q;
  assign writeRegOut  = wreg_q;
  assign haltOut      = halt_q;
  assign validOut     = valid_q;
  assign forwardC     = fwd_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - directed self-checking bench for ex_mem_reg
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluResult, writeData, memDataMemWb;
  logic [2:0]  storeSrcReg, writeReg;
  logic        MemWrite, MemRead, RegWrite, MemToReg, halt, valid, stall, flush;
  logic [15:0] memAddr, writeDataOut;
  logic        MemWriteOut, MemReadOut, RegWriteOut, MemToRegOut, haltOut, validOut, forwardC, halted;
  logic [2:0]  writeRegOut;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst),
    .aluResult(aluResult), .writeData(writeData), .storeSrcReg(storeSrcReg),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .writeReg(writeReg), .halt(halt), .valid(valid), .stall(stall), .flush(flush),
    .memDataMemWb(memDataMemWb),
    .memAddr(memAddr), .writeDataOut(writeDataOut), .MemWriteOut(MemWriteOut),
    .MemReadOut(MemReadOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .writeRegOut(writeRegOut), .haltOut(haltOut), .validOut(validOut),
    .forwardC(forwardC), .halted(halted)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [15:0] a, input logic [15:0] wd, input logic [2:0] src,
                        input logic mw, input logic mr, input logic rw, input logic m2r,
                        input logic [2:0] wr, input logic h, input logic v);
    aluResult = a; writeData = wd; storeSrcReg = src; MemWrite = mw; MemRead = mr;
    RegWrite = rw; MemToReg = m2r; writeReg = wr; halt = h; valid = v;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; memDataMemWb = 16'h0;
    set_ex(16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0);
    #12;
    check("rst_memAddr", memAddr, 16'h0);
    check("rst_writeDataOut", writeDataOut, 16'h0);
    check("rst_validOut", {15'b0, validOut}, 16'h0);
    check("rst_halted", {15'b0, halted}, 16'h0);
    check("rst_forwardC", {15'b0, forwardC}, 16'h0);

    // load r3 from memory, first edge after reset release
    set_ex(16'h1234, 16'hAAAA, 3'd0, 0, 1, 1, 1, 3'd3, 0, 1);
    rst = 1'b1;
    step();
    check("load_memAddr", memAddr, 16'h1234);
    check("load_writeDataOut", writeDataOut, 16'hAAAA);
    check("load_ctrl", {11'b0, MemWriteOut, MemReadOut, RegWriteOut, MemToRegOut, validOut}, 16'h000F);
    check("load_writeRegOut", {13'b0, writeRegOut}, 16'h0003);
    check("load_forwardC", {15'b0, forwardC}, 16'h0);

    // store of r3 right behind it
    set_ex(16'h0040, 16'h1111, 3'd3, 1, 0, 0, 0, 3'd0, 0, 1);
    step();
    check("store3_forwardC", {15'b0, forwardC}, 16'h1);
    check("store3_MemWriteOut", {15'b0, MemWriteOut}, 16'h1);
    check("store3_writeDataOut", writeDataOut, 16'h1111);

    stall = 1'b1; memDataMemWb = 16'hBEEF;
    set_ex(16'h9999, 16'h9999, 3'd7, 0, 0, 1, 0, 3'd7, 0, 1);
    step();
    check("stall1_writeDataOut", writeDataOut, 16'hBEEF);
    check("stall1_forwardC", {15'b0, forwardC}, 16'h0);
    check("stall1_memAddr", memAddr, 16'h0040);
    memDataMemWb = 16'h1234;
    step();
    check("stall2_writeDataOut", writeDataOut, 16'hBEEF);
    check("stall2_forwardC", {15'b0, forwardC}, 16'h0);
    check("stall2_RegWriteOut", {15'b0, RegWriteOut}, 16'h0);

    // same pair, but the store reads r4
    stall = 1'b0;
    set_ex(16'h1234, 16'hAAAA, 3'd0, 0, 1, 1, 1, 3'd3, 0, 1);
    step();
    set_ex(16'h0042, 16'h2222, 3'd4, 1, 0, 0, 0, 3'd0, 0, 1);
    step();
    check("store4_forwardC", {15'b0, forwardC}, 16'h0);
    check("store4_MemWriteOut", {15'b0, MemWriteOut}, 16'h1);

    // reload r3 then check flush+stall over a pending store
    set_ex(16'h1234, 16'hAAAA, 3'd0, 0, 1, 1, 1, 3'd3, 0, 1);
    step();
    flush = 1'b1; stall = 1'b1;
    set_ex(16'h5A5A, 16'h5A5A, 3'd3, 1, 1, 1, 1, 3'd5, 1, 1);
    step();
    check("flush_ctrl", {9'b0, MemWriteOut, MemReadOut, RegWriteOut, MemToRegOut, validOut, haltOut, forwardC}, 16'h0);
    check("flush_memAddr", memAddr, 16'h1234);
    check("flush_writeDataOut", writeDataOut, 16'hAAAA);
    check("flush_writeRegOut", {13'b0, writeRegOut}, 16'h0003);
    flush = 1'b0; stall = 1'b0;
    set_ex(16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1);
    step();
    check("flush_halt_dropped", {15'b0, haltOut}, 16'h0);

    // invalid slot carrying MemWrite and halt
    set_ex(16'h5555, 16'h6666, 3'd1, 1, 0, 0, 0, 3'd2, 1, 0);
    step();
    check("inv_MemWriteOut", {15'b0, MemWriteOut}, 16'h0);
    check("inv_haltOut", {15'b0, haltOut}, 16'h0);
    check("inv_memAddr", memAddr, 16'h5555);
    set_ex(16'h0001, 16'h0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1);
    step();
    check("inv_still_run", {14'b0, haltOut, halted}, 16'h0);
    check("inv_next_load", memAddr, 16'h0001);

    // halt followed by stores
    set_ex(16'h0100, 16'h0200, 3'd0, 1, 0, 0, 0, 3'd0, 1, 1);
    step();
    check("halt_haltOut", {15'b0, haltOut}, 16'h1);
    check("halt_halted", {15'b0, halted}, 16'h0);
    set_ex(16'h0300, 16'h0400, 3'd0, 1, 0, 0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("done_haltOut", {15'b0, haltOut}, 16'h0);
      check("done_halted", {15'b0, halted}, 16'h1);
      check("done_MemWriteOut", {15'b0, MemWriteOut}, 16'h0);
      check("done_validOut", {15'b0, validOut}, 16'h0);
    end

    // async reset out of DONE, then async reset inside HALT_SEEN
    rst = 1'b0;
    #1;
    check("arst_done_halted", {15'b0, halted}, 16'h0);
    rst = 1'b1;
    set_ex(16'h0500, 16'h0600, 3'd0, 0, 0, 0, 0, 3'd0, 1, 1);
    step();
    check("hs_haltOut", {15'b0, haltOut}, 16'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_hs_haltOut", {15'b0, haltOut}, 16'h0);
    check("arst_hs_memAddr", memAddr, 16'h0);
    check("arst_hs_writeDataOut", writeDataOut, 16'h0);
    check("arst_hs_validOut", {15'b0, validOut}, 16'h0);
    rst = 1'b1;
    set_ex(16'h7777, 16'h8888, 3'd0, 0, 0, 1, 0, 3'd6, 0, 1);
    step();
    check("post_rst_memAddr", memAddr, 16'h7777);
    check("post_rst_ctrl", {13'b0, RegWriteOut, validOut, halted}, 16'h0006);
    check("post_rst_writeRegOut", {13'b0, writeRegOut}, 16'h0006);
    step();
    check("post_rst_no_pulse", {14'b0, haltOut, halted}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
